// File: rtl/rbcp_pkg.sv
// Shared RBCP definitions: bus widths, pipeline latency and the stage-1 request record.
package rbcp_pkg;

  localparam int unsigned RBCP_ACK_LAT = 2;   // strobe-to-ACK latency in cycles
  localparam int unsigned RBCP_DW      = 8;   // RBCP data width
  localparam int unsigned RBCP_AW      = 32;  // RBCP address width
  localparam int unsigned RBCP_OFF_W   = 6;   // in-window register offset width

  // Request captured in stage 1 of the responder pipeline.
  typedef struct packed {
    logic                  hit;
    logic                  we;
    logic [RBCP_OFF_W-1:0] off;
    logic [RBCP_DW-1:0]    wd;
  } rbcp_req_t;

endpackage

// File: rtl/rbcp_addr_decode.sv
// Combinational RBCP window decoder.
//   addr  : RBCP byte address
//   hit_c : address falls inside [BASE_ADDR, BASE_ADDR+NUM_REGS)
//   off_c : low bits of (addr - BASE_ADDR), meaningful only when hit_c is set
module rbcp_addr_decode
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_AW-1:0] BASE_ADDR = '0,
  parameter int unsigned        NUM_REGS  = 16
) (
  input  logic [RBCP_AW-1:0]    addr,
  output logic                  hit_c,
  output logic [RBCP_OFF_W-1:0] off_c
);

  logic [RBCP_AW-1:0] offset_c;

  // Lower-bound test guards against the subtraction wrapping for addresses below the base.
  always_comb begin
    offset_c = addr - BASE_ADDR;
    hit_c    = (addr >= BASE_ADDR) && (offset_c < RBCP_AW'(NUM_REGS));
    off_c    = offset_c[RBCP_OFF_W-1:0];
  end

endmodule

// File: rtl/rbcp_reg_slave.sv
// RBCP responder: byte-wide register window on the SiTCP local bus.
//   CLK, RST          : user clock, synchronous active-high reset
//   RBCP_ACT/ADDR/WE/WD/RE : SiTCP initiator side
//   RBCP_ACK, RBCP_RD : 1-cycle acknowledge and read data, 2 cycles after the strobe
//   REG_OUT           : RW control registers (offsets 0..NUM_RW-1)
//   REG_WR_PULSE      : per-register write pulse, aligned with ACK
//   STAT_IN           : RO status bytes (offsets NUM_RW..NUM_RW+NUM_RO-1)
//   ACC_CNT           : acknowledged accesses, wrapping
//   ERR_CNT           : out-of-window accesses, saturating
// The whole window (NUM_RW+NUM_RO) must fit in the 6-bit offset space.
module rbcp_reg_slave
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned        NUM_RW    = 8,
  parameter int unsigned        NUM_RO    = 8,
  parameter logic [8*NUM_RW-1:0] RW_INIT  = '0
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      RBCP_ACT,
  input  logic [RBCP_AW-1:0]                        RBCP_ADDR,
  input  logic                                      RBCP_WE,
  input  logic [RBCP_DW-1:0]                        RBCP_WD,
  input  logic                                      RBCP_RE,
  output logic                                      RBCP_ACK,
  output logic [RBCP_DW-1:0]                        RBCP_RD,
  output logic [8*NUM_RW-1:0]                       REG_OUT,
  output logic [NUM_RW-1:0]                         REG_WR_PULSE,
  input  logic [8*((NUM_RO == 0) ? 1 : NUM_RO)-1:0] STAT_IN,
  output logic [15:0]                               ACC_CNT,
  output logic [7:0]                                ERR_CNT
);

  localparam int unsigned NUM_REGS = NUM_RW + NUM_RO;

  logic                  strobe_c;
  logic                  dec_hit_c;
  logic [RBCP_OFF_W-1:0] dec_off_c;
  logic [RBCP_DW-1:0]    stat_sel_c;

  logic                  s1_valid;
  rbcp_req_t             s1_req;
  logic [RBCP_DW-1:0]    s1_stat;

  logic                  is_rw_c;
  logic [RBCP_DW-1:0]    rw_rd_c;
  logic                  ack_nxt_c;
  logic [RBCP_DW-1:0]    rd_nxt_c;
  logic [8*NUM_RW-1:0]   reg_nxt_c;
  logic [NUM_RW-1:0]     pulse_nxt_c;
  logic [15:0]           acc_nxt_c;
  logic [7:0]            err_nxt_c;

  // WE together with RE is handled as a write.
  assign strobe_c = RBCP_ACT & (RBCP_WE | RBCP_RE);

  rbcp_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .addr  (RBCP_ADDR),
    .hit_c (dec_hit_c),
    .off_c (dec_off_c)
  );

  // Status byte addressed by the incoming strobe, snapshotted into stage 1.
  always_comb begin
    stat_sel_c = '0;
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if ({1'b0, dec_off_c} == 7'(NUM_RW + k)) stat_sel_c = STAT_IN[8*k +: 8];
    end
  end

  // Stage 1: capture the decoded request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_stat  <= '0;
    end else begin
      s1_valid <= strobe_c;
      s1_req   <= '{hit: dec_hit_c, we: RBCP_WE, off: dec_off_c, wd: RBCP_WD};
      s1_stat  <= stat_sel_c;
    end
  end

  // Stage 2 next-state. A read following a write to the same RW register sees
  // REG_OUT already updated by the earlier stage-2 cycle, so no bypass path is needed.
  always_comb begin
    reg_nxt_c   = REG_OUT;
    pulse_nxt_c = '0;
    ack_nxt_c   = 1'b0;
    rd_nxt_c    = RBCP_RD;
    acc_nxt_c   = ACC_CNT;
    err_nxt_c   = ERR_CNT;
    rw_rd_c     = '0;
    is_rw_c     = ({1'b0, s1_req.off} < 7'(NUM_RW));

    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (s1_req.off == RBCP_OFF_W'(k)) rw_rd_c = REG_OUT[8*k +: 8];
    end

    if (s1_valid) begin
      if (s1_req.hit) begin
        ack_nxt_c = 1'b1;
        acc_nxt_c = ACC_CNT + 16'd1;
        if (is_rw_c) begin
          if (s1_req.we) begin
            rd_nxt_c = s1_req.wd;
            for (int unsigned k = 0; k < NUM_RW; k++) begin
              if (s1_req.off == RBCP_OFF_W'(k)) begin
                reg_nxt_c[8*k +: 8] = s1_req.wd;
                pulse_nxt_c[k]      = 1'b1;
              end
            end
          end else begin
            rd_nxt_c = rw_rd_c;
          end
        end else begin
          // RO offset: writes are dropped but still acknowledged with the status byte.
          rd_nxt_c = s1_stat;
        end
      end else if (ERR_CNT != 8'hFF) begin
        err_nxt_c = ERR_CNT + 8'd1;
      end
    end
  end

  // Stage 2 registers: bus response, register file and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RBCP_ACK     <= 1'b0;
      RBCP_RD      <= '0;
      REG_OUT      <= RW_INIT;
      REG_WR_PULSE <= '0;
      ACC_CNT      <= '0;
      ERR_CNT      <= '0;
    end else begin
      RBCP_ACK     <= ack_nxt_c;
      RBCP_RD      <= rd_nxt_c;
      REG_OUT      <= reg_nxt_c;
      REG_WR_PULSE <= pulse_nxt_c;
      ACC_CNT      <= acc_nxt_c;
      ERR_CNT      <= err_nxt_c;
    end
  end

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Self-checking bench for rbcp_reg_slave: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_rbcp_reg_slave;
  import rbcp_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned NRW  = 8;
  localparam int unsigned NRO  = 8;
  localparam logic [63:0] INIT = 64'h8877_6655_4433_22F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rbcp_act;
  logic [31:0] rbcp_addr;
  logic        rbcp_we;
  logic [7:0]  rbcp_wd;
  logic        rbcp_re;
  logic        rbcp_ack;
  logic [7:0]  rbcp_rd;
  logic [63:0] reg_out;
  logic [7:0]  reg_wr_pulse;
  logic [63:0] stat_in;
  logic [15:0] acc_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rbcp_reg_slave #(
    .BASE_ADDR (BASE),
    .NUM_RW    (NRW),
    .NUM_RO    (NRO),
    .RW_INIT   (INIT)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .RBCP_ACT     (rbcp_act),
    .RBCP_ADDR    (rbcp_addr),
    .RBCP_WE      (rbcp_we),
    .RBCP_WD      (rbcp_wd),
    .RBCP_RE      (rbcp_re),
    .RBCP_ACK     (rbcp_ack),
    .RBCP_RD      (rbcp_rd),
    .REG_OUT      (reg_out),
    .REG_WR_PULSE (reg_wr_pulse),
    .STAT_IN      (stat_in),
    .ACC_CNT      (acc_cnt),
    .ERR_CNT      (err_cnt)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic w, input logic r,
                       input logic [31:0] ad, input logic [7:0] d);
    rbcp_act  = a;
    rbcp_we   = w;
    rbcp_re   = r;
    rbcp_addr = ad;
    rbcp_wd   = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic        ack;
    logic [7:0]  rd;
    logic [7:0]  pulse;
    logic [63:0] regs;
    logic [15:0] acc;
    logic [7:0]  err;
  } exp_t;

  logic [7:0]  m_rw   [NRW];
  logic [7:0]  m_stat [NRO];
  logic [7:0]  m_rd;
  logic [15:0] m_acc;
  logic [7:0]  m_err;
  exp_t        q[$];

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) m_rw[i] = INIT[8*i +: 8];
    m_rd  = 8'h00;
    m_acc = 16'h0;
    m_err = 8'h00;
    q.delete();
  endtask

  // Applies one bus cycle atomically and queues the outputs it should produce.
  task automatic model_apply(input logic a, input logic w, input logic r,
                             input logic [31:0] ad, input logic [7:0] d);
    exp_t e;
    logic [31:0] o;
    e.ack   = 1'b0;
    e.pulse = 8'h00;
    if (a && (w || r)) begin
      o = ad - BASE;
      if (ad >= BASE && o < NRW + NRO) begin
        e.ack = 1'b1;
        m_acc = m_acc + 16'd1;
        if (o < NRW) begin
          if (w) begin
            m_rw[o] = d;
            e.pulse = 8'(1) << o;
            m_rd    = d;
          end else begin
            m_rd = m_rw[o];
          end
        end else begin
          m_rd = m_stat[o - NRW];
        end
      end else if (m_err != 8'hFF) begin
        m_err = m_err + 8'd1;
      end
    end
    e.rd  = m_rd;
    e.acc = m_acc;
    e.err = m_err;
    for (int i = 0; i < NRW; i++) e.regs[8*i +: 8] = m_rw[i];
    q.push_back(e);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        act;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        exp_ack;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_pulse;
    logic [63:0] exp_reg;
    logic [15:0] exp_acc;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vt[10];

  initial begin : main
    logic [63:0] r1;
    logic [63:0] r2;
    logic        saw_ack;
    exp_t        e;
    logic        a, w, r;
    logic [31:0] ad;
    logic [7:0]  d;

    rst     = 1'b1;
    stat_in = 64'h3736_3534_3332_3C30;
    idle();

    r1 = 64'h8877_6655_44A5_22F0;
    r2 = 64'h5A77_6655_44A5_22F0;
    vt[0] = '{1'b1, 1'b1, 1'b0, BASE + 32'd2,  8'hA5, 1'b1, 8'hA5, 8'h04, r1, 16'd1, 8'd0};
    vt[1] = '{1'b1, 1'b0, 1'b1, BASE + 32'd2,  8'h00, 1'b1, 8'hA5, 8'h00, r1, 16'd2, 8'd0};
    vt[2] = '{1'b1, 1'b0, 1'b1, BASE + 32'd9,  8'h00, 1'b1, 8'h3C, 8'h00, r1, 16'd3, 8'd0};
    vt[3] = '{1'b1, 1'b1, 1'b0, BASE + 32'd9,  8'hFF, 1'b1, 8'h3C, 8'h00, r1, 16'd4, 8'd0};
    vt[4] = '{1'b1, 1'b0, 1'b1, BASE + 32'd5,  8'h00, 1'b1, 8'h66, 8'h00, r1, 16'd5, 8'd0};
    vt[5] = '{1'b1, 1'b0, 1'b1, BASE + 32'd16, 8'h00, 1'b0, 8'h66, 8'h00, r1, 16'd5, 8'd1};
    vt[6] = '{1'b1, 1'b0, 1'b1, BASE - 32'd1,  8'h00, 1'b0, 8'h66, 8'h00, r1, 16'd5, 8'd2};
    vt[7] = '{1'b1, 1'b1, 1'b1, BASE + 32'd7,  8'h5A, 1'b1, 8'h5A, 8'h80, r2, 16'd6, 8'd2};
    vt[8] = '{1'b0, 1'b1, 1'b0, BASE + 32'd3,  8'h99, 1'b0, 8'h5A, 8'h00, r2, 16'd6, 8'd2};
    vt[9] = '{1'b1, 1'b0, 1'b1, BASE + 32'd15, 8'h00, 1'b1, 8'h37, 8'h00, r2, 16'd7, 8'd2};

    // Reset state
    step();
    step();
    check("rst_ack",   rbcp_ack,     0);
    check("rst_rd",    rbcp_rd,      0);
    check("rst_reg",   reg_out,      INIT);
    check("rst_pulse", reg_wr_pulse, 0);
    check("rst_acc",   acc_cnt,      0);
    check("rst_err",   err_cnt,      0);
    rst = 1'b0;
    step();

    // Table: ACT is dropped right after each strobe, so every entry also
    // exercises completion of an in-flight access with ACT low.
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].act, vt[i].we, vt[i].re, vt[i].addr, vt[i].wd);
      step();
      idle();
      check($sformatf("tbl%0d_early_ack", i), rbcp_ack, 0);
      for (int s = 1; s < int'(RBCP_ACK_LAT); s++) step();
      check($sformatf("tbl%0d_ack", i),   rbcp_ack,     vt[i].exp_ack);
      check($sformatf("tbl%0d_rd", i),    rbcp_rd,      vt[i].exp_rd);
      check($sformatf("tbl%0d_pulse", i), reg_wr_pulse, vt[i].exp_pulse);
      check($sformatf("tbl%0d_reg", i),   reg_out,      vt[i].exp_reg);
      check($sformatf("tbl%0d_acc", i),   acc_cnt,      vt[i].exp_acc);
      check($sformatf("tbl%0d_err", i),   err_cnt,      vt[i].exp_err);
      step();
      check($sformatf("tbl%0d_ack_end", i),   rbcp_ack,     0);
      check($sformatf("tbl%0d_pulse_end", i), reg_wr_pulse, 0);
    end

    // Back-to-back write then read of the same RW register
    drive(1'b1, 1'b1, 1'b0, BASE, 8'h11);
    step();
    drive(1'b1, 1'b0, 1'b1, BASE, 8'h00);
    step();
    idle();
    check("b2b_ack1",   rbcp_ack,     1);
    check("b2b_rd1",    rbcp_rd,      8'h11);
    check("b2b_pulse1", reg_wr_pulse, 8'h01);
    step();
    check("b2b_ack2",   rbcp_ack,     1);
    check("b2b_rd2",    rbcp_rd,      8'h11);
    check("b2b_pulse2", reg_wr_pulse, 8'h00);
    check("b2b_reg",    reg_out,      64'h5A77_6655_44A5_2211);
    check("b2b_acc",    acc_cnt,      16'd9);
    step();
    check("b2b_ack3",   rbcp_ack,     0);

    // Reset one cycle after a write strobe drops the access
    drive(1'b1, 1'b1, 1'b0, BASE + 32'd1, 8'hEE);
    step();
    idle();
    rst = 1'b1;
    step();
    check("rstmid_ack", rbcp_ack, 0);
    check("rstmid_reg", reg_out,  INIT);
    check("rstmid_acc", acc_cnt,  0);
    rst = 1'b0;
    step();
    check("rstmid_ack2",   rbcp_ack,     0);
    check("rstmid_pulse2", reg_wr_pulse, 0);
    check("rstmid_reg2",   reg_out,      INIT);

    // 300 consecutive misses saturate ERR_CNT and never ACK
    saw_ack = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 1'b1, BASE + 32'd100, 8'h00);
      step();
      if (rbcp_ack) saw_ack = 1'b1;
    end
    idle();
    step();
    if (rbcp_ack) saw_ack = 1'b1;
    step();
    if (rbcp_ack) saw_ack = 1'b1;
    check("miss_noack", saw_ack, 0);
    check("miss_sat",   err_cnt, 8'hFF);
    check("miss_rd",    rbcp_rd, 0);
    check("miss_reg",   reg_out, INIT);

    // Randomized run against the model
    rst = 1'b1;
    idle();
    step();
    rst     = 1'b0;
    stat_in = {$urandom(), $urandom()};
    for (int i = 0; i < NRO; i++) m_stat[i] = stat_in[8*i +: 8];
    model_reset();
    for (int i = 0; i < 1502; i++) begin
      if (i < 1500) begin
        a = ($urandom_range(0, 9) != 0);
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0:       ad = BASE - 32'd1 - 32'($urandom_range(0, 3));
          1:       ad = BASE + 32'd16 + 32'($urandom_range(0, 3));
          2:       ad = $urandom();
          default: ad = BASE + 32'($urandom_range(0, 15));
        endcase
        d = 8'($urandom());
      end else begin
        a = 1'b0; w = 1'b0; r = 1'b0; ad = 32'h0; d = 8'h00;
      end
      drive(a, w, r, ad, d);
      model_apply(a, w, r, ad, d);
      step();
      if (q.size() == int'(RBCP_ACK_LAT)) begin
        e = q.pop_front();
        check($sformatf("rnd%0d_ack", i),   rbcp_ack,     e.ack);
        check($sformatf("rnd%0d_rd", i),    rbcp_rd,      e.rd);
        check($sformatf("rnd%0d_pulse", i), reg_wr_pulse, e.pulse);
        check($sformatf("rnd%0d_reg", i),   reg_out,      e.regs);
        check($sformatf("rnd%0d_acc", i),   acc_cnt,      e.acc);
        check($sformatf("rnd%0d_err", i),   err_cnt,      e.err);
      end
    end
    idle();

    // ACC_CNT wrap after 65536 acknowledged reads
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b0, 1'b1, BASE + 32'd8, 8'h00);
      step();
    end
    idle();
    step();
    step();
    check("wrap_ffff", acc_cnt, 16'hFFFF);
    drive(1'b1, 1'b0, 1'b1, BASE + 32'd3, 8'h00);
    step();
    idle();
    step();
    check("wrap_ack", rbcp_ack, 1);
    check("wrap_rd",  rbcp_rd,  8'h44);
    check("wrap_0",   acc_cnt,  16'h0000);
    step();

    // Strobe with ACT low is ignored
    drive(1'b0, 1'b0, 1'b1, BASE + 32'd3, 8'h00);
    step();
    idle();
    step();
    check("noact_ack", rbcp_ack, 0);
    check("noact_acc", acc_cnt,  16'h0000);
    check("noact_err", err_cnt,  8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
